// File: rtl/vslc_loader_pkg.sv
// Shared types and constants for the VSLC serial program loader.
package vslc_loader_pkg;

  localparam int         BYTE_W    = 8;
  localparam logic [7:0] HDR_WRITE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/vslc_sync2.sv
// Parameterizable-width two-flop synchronizer with async active-high reset.
module vslc_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // NOTE: flops use non-blocking assignments so every stage samples the
  // pre-edge value of the previous one; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vslc_prog_loader.sv
// Serial program loader: SPI mode-0 frames into program-memory writes.
// Optional miso echo of the previous byte under `VSLC_PROG_LOADER_ECHO_EN.
module vslc_prog_loader
  import vslc_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              mosi_i,
  input  logic              cs_n_i,
  output logic              miso_o,
  output logic [ADDR_W-1:0] prog_addr_o,
  output logic [WORD_W-1:0] prog_data_o,
  output logic              prog_we_o,
  input  logic              prog_ready_i,
  output logic              core_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int         BPW      = WORD_W / BYTE_W;
  localparam logic [7:0] LAST_IDX = 8'(BPW - 1);

  // ---------------------------------------------------------------------------
  // Pin synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic [2:0] pins_s;
  logic       sclk_s, mosi_s, cs_n_s;

  vslc_sync2 #(
    .WIDTH  (3),
    .RST_VAL(3'b001)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({sclk_i, mosi_i, cs_n_i}),
    .q_o (pins_s)
  );

  assign sclk_s = pins_s[2];
  assign mosi_s = pins_s[1];
  assign cs_n_s = pins_s[0];

  logic sclk_prev_q, sclk_prev_d;
  logic cs_n_prev_q, cs_n_prev_d;
  logic sclk_rise, cs_fall, cs_rise;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;

  // ---------------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------------
  logic [BYTE_W-2:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              byte_done;
  logic [BYTE_W-1:0] rx_byte;

  assign rx_byte   = {shift_q, mosi_s};
  assign byte_done = ~cs_n_s & sclk_rise & (bit_cnt_q == 3'd7);

  // NOTE: every variable written in an always_comb gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    sclk_prev_d = sclk_s;
    cs_n_prev_d = cs_n_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    if (cs_n_s) begin
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d   = rx_byte[BYTE_W-2:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              pend_err_q, pend_err_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cs_fall) state_d = HDR;
      HDR: begin
        if (cs_rise)        state_d = ERR;
        else if (byte_done) state_d = (rx_byte == HDR_WRITE) ? CNT : ERR;
      end
      CNT: begin
        if (cs_rise)        state_d = ERR;
        else if (byte_done) state_d = (rx_byte == 8'h00) ? CSUM : DATA;
      end
      DATA: begin
        if (cs_rise)                                 state_d = ERR;
        else if (byte_done && byte_idx_q == LAST_IDX) state_d = WRITE;
      end
      WRITE: begin
        // Aborts seen while the write is pending take effect only on acceptance.
        if (prog_ready_i) begin
          if (pend_err_q || cs_rise || byte_done) state_d = ERR;
          else if (cnt_q == 8'd1)                 state_d = CSUM;
          else                                    state_d = DATA;
        end
      end
      CSUM: begin
        if (cs_rise)        state_d = ERR;
        else if (byte_done) state_d = (rx_byte == csum_q) ? DONE : ERR;
      end
      DONE, ERR: if (cs_n_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_o_comb: begin
      prog_we_o   = (state_q == WRITE);
      prog_addr_o = addr_q;
      prog_data_o = word_q;
      core_hold_o = hold_q;
      done_o      = done_q;
      err_o       = err_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d     = addr_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    pend_err_d = (state_q == WRITE) ? (pend_err_q | cs_rise | byte_done) : 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          addr_d     = '0;
          csum_d     = '0;
          byte_idx_d = '0;
          hold_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      CNT: if (byte_done) cnt_d = rx_byte;
      DATA: begin
        if (byte_done) begin
          word_d     = (word_q << BYTE_W) | WORD_W'(rx_byte);
          csum_d     = csum_q ^ rx_byte;
          byte_idx_d = (byte_idx_q == LAST_IDX) ? 8'd0 : byte_idx_q + 8'd1;
        end
      end
      WRITE: begin
        if (prog_ready_i) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase

    if (state_d == DONE && state_q != DONE) done_d = 1'b1;
    if (state_d == ERR  && state_q != ERR)  err_d  = 1'b1;
    if (state_d == IDLE && state_q != IDLE) hold_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      pend_err_q <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      pend_err_q <= pend_err_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional miso echo
  // ---------------------------------------------------------------------------
`ifdef VSLC_PROG_LOADER_ECHO_EN
  logic              sclk_fall;
  logic [BYTE_W-1:0] last_q, last_d;
  logic [BYTE_W-1:0] tx_q, tx_d;

  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // The falling edge after a byte boundary loads the byte just received so
  // its MSB is on the pin before the next rising edge.
  always_comb begin
    last_d = last_q;
    tx_d   = tx_q;
    if (byte_done) last_d = rx_byte;
    if (cs_fall) begin
      tx_d = '0;
    end else if (~cs_n_s && sclk_fall) begin
      tx_d = (bit_cnt_q == 3'd0) ? last_q : {tx_q[BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
      tx_q   <= '0;
    end else begin
      last_q <= last_d;
      tx_q   <= tx_d;
    end
  end

  assign miso_o = tx_q[BYTE_W-1];
`else
  assign miso_o = 1'b0;
`endif

endmodule
